rca_lsq_arbiter: RTL and testbench
==================================

RCA_LSQ_ARBITER -- requirements
Module: rca_lsq_arbiter

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of grid PR slots sharing one LSQ port, range 2..8.
REQ-002 Parameter TAG_DEPTH, default 4: load-return tag FIFO depth, power of 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 slot_addr / slot_data  input  NUM_SLOTS x XLEN  per-slot request address / store data.
REQ-006 slot_fn3  input  NUM_SLOTS x 3  per-slot access size/sign code.
REQ-007 slot_load / slot_store / slot_new_request  input  NUM_SLOTS  per-slot request type and strobe.
REQ-008 slot_lsq_full  output  NUM_SLOTS  per-slot back-pressure.
REQ-009 slot_rd_valid  output  NUM_SLOTS  one-hot load-data return strobe; slot_rd_data  output  XLEN  shared return data.
REQ-010 lsq_addr / lsq_data  output  XLEN; lsq_fn3  output  3; lsq_load / lsq_store / lsq_new_request  output  1: shared LSQ port.
REQ-011 lsq_full  input  1  LSQ cannot accept a request this cycle.
REQ-012 lsq_rd_valid  input  1, lsq_rd_data  input  XLEN: in-order load data from LSQ.
REQ-013 err_overflow / err_underflow  output  1  sticky protocol error flags.

Function
REQ-014 Each slot SHALL own a one-entry holding register (addr, data, fn3, load, store, valid).
REQ-015 Capture: slot_new_request[i] with hold_valid[i]=0 SHALL load holding register i at the clock edge.
REQ-016 slot_lsq_full[i] SHALL equal hold_valid[i] (registered; no combinational path from lsq_full).
REQ-017 slot_new_request[i] while hold_valid[i]=1 SHALL be discarded and SHALL set err_overflow.
REQ-018 A captured request with load=0 and store=0 SHALL not be held; load=1 and store=1 SHALL be treated as load.
REQ-019 Eligible[i] = hold_valid[i] AND (store OR tag FIFO not full).
REQ-020 Grant: when lsq_full=0 and any slot eligible, SHALL select the first eligible slot at or after rr_ptr, wrapping modulo NUM_SLOTS.
REQ-021 lsq_* outputs SHALL be driven combinationally from the granted holding register; lsq_new_request=1 only in a grant cycle; otherwise all lsq_* outputs 0.
REQ-022 On grant to slot g: hold_valid[g] cleared and rr_ptr set to (g+1) mod NUM_SLOTS at that edge; rr_ptr otherwise unchanged.
REQ-023 Minimum latency: slot strobe in cycle T -> lsq_new_request in cycle T+1; slot_lsq_full drops in cycle T+2.
REQ-024 Granted load SHALL push slot index g into the tag FIFO in the grant cycle.
REQ-025 lsq_rd_valid=1 with FIFO non-empty: pop head h, assert slot_rd_valid[h] same cycle, slot_rd_data=lsq_rd_data.
REQ-026 lsq_rd_valid=1 with FIFO empty: no slot_rd_valid, set err_underflow.
REQ-027 Simultaneous push and pop SHALL be legal at any occupancy, including full (count unchanged) and empty (push then pop not bypassed: data return requires prior-cycle grant).
REQ-028 Stores blocked only by lsq_full; loads additionally blocked while tag FIFO full; stores from other slots SHALL still be granted.
REQ-029 slot_rd_data SHALL be 0 when no slot_rd_valid is asserted.

Reset
REQ-030 rst low SHALL immediately clear hold_valid, tag FIFO pointers/count, rr_ptr (=0), err flags; all outputs 0.
REQ-031 Reset mid-operation SHALL discard held requests and outstanding load tags; no response routed afterward until new loads issue.
REQ-032 First edge after rst deasserts SHALL accept requests normally.

Verification
REQ-033 All 4 slots strobe store in one cycle, lsq_full=0 -> grants slots 0,1,2,3 in consecutive cycles; rr_ptr ends 0.
REQ-034 Slot 2 load then slot 0 load; lsq returns 0xAAAA then 0xBBBB -> slot_rd_valid=0100 with 0xAAAA, then 0001 with 0xBBBB.
REQ-035 TAG_DEPTH=4 loads outstanding, slot 1 load and slot 3 store held -> slot 3 granted, slot 1 held until one lsq_rd_valid.
REQ-036 lsq_full held high 5 cycles with slot 0 held, slot 0 strobes again -> no issue, err_overflow=1, request issued once after lsq_full falls.
REQ-037 lsq_rd_valid with empty tag FIFO -> no slot_rd_valid, err_underflow=1 until reset.
REQ-038 rst asserted with 2 loads outstanding and 3 held requests -> all outputs 0 immediately; later lsq_rd_valid raises err_underflow.

Source files
------------

// File: rtl/rca_lsq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rca_lsq_arbiter
// Purpose  : Shares one LSQ port among NUM_SLOTS grid PR slots. Each slot
//            has a one-entry holding register. A round-robin arbiter issues
//            one held request per cycle. Load data returns in order and is
//            routed back to the issuing slot through a tag FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active low
//   slot_addr/slot_data      per-slot request address / store data
//   slot_fn3                 per-slot access size/sign code
//   slot_load/slot_store     per-slot request type
//   slot_new_request         per-slot request strobe
//   slot_lsq_full            per-slot back-pressure (holding register busy)
//   slot_rd_valid            one-hot load-data return strobe
//   slot_rd_data             shared load return data (0 when idle)
//   lsq_addr/lsq_data/lsq_fn3/lsq_load/lsq_store/lsq_new_request
//                            shared LSQ request port
//   lsq_full                 LSQ cannot accept a request this cycle
//   lsq_rd_valid/lsq_rd_data in-order load data returned by the LSQ
//   err_overflow             sticky: strobe arrived while slot was busy
//   err_underflow            sticky: load data arrived with no tag pending
// ============================================================================
module rca_lsq_arbiter #(
  parameter int NUM_SLOTS = 4,
  parameter int TAG_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SLOTS-1:0][XLEN-1:0]  slot_addr,
  input  logic [NUM_SLOTS-1:0][XLEN-1:0]  slot_data,
  input  logic [NUM_SLOTS-1:0][2:0]       slot_fn3,
  input  logic [NUM_SLOTS-1:0]            slot_load,
  input  logic [NUM_SLOTS-1:0]            slot_store,
  input  logic [NUM_SLOTS-1:0]            slot_new_request,
  output logic [NUM_SLOTS-1:0]            slot_lsq_full,
  output logic [NUM_SLOTS-1:0]            slot_rd_valid,
  output logic [XLEN-1:0]                 slot_rd_data,
  output logic [XLEN-1:0]                 lsq_addr,
  output logic [XLEN-1:0]                 lsq_data,
  output logic [2:0]                      lsq_fn3,
  output logic                            lsq_load,
  output logic                            lsq_store,
  output logic                            lsq_new_request,
  input  logic                            lsq_full,
  input  logic                            lsq_rd_valid,
  input  logic [XLEN-1:0]                 lsq_rd_data,
  output logic                            err_overflow,
  output logic                            err_underflow
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  // Holding registers
  logic [NUM_SLOTS-1:0][XLEN-1:0] r_hold_addr;
  logic [NUM_SLOTS-1:0][XLEN-1:0] r_hold_data;
  logic [NUM_SLOTS-1:0][2:0]      r_hold_fn3;
  logic [NUM_SLOTS-1:0]           r_hold_load;
  logic [NUM_SLOTS-1:0]           r_hold_store;
  logic [NUM_SLOTS-1:0]           r_hold_valid;

  // Arbitration
  logic [SLOT_W-1:0]              r_rr_ptr;
  logic [NUM_SLOTS-1:0]           w_eligible;
  logic [SLOT_W:0]                w_cand;
  logic [SLOT_W-1:0]              w_grant_idx;
  logic                           w_found;
  logic                           w_grant;

  // Tag FIFO
  logic [TAG_DEPTH-1:0][SLOT_W-1:0] r_tag_mem;
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_count;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_push;
  logic                           w_pop;

  logic                           r_err_overflow;
  logic                           r_err_underflow;

  assign w_full  = (r_count == CNT_W'(TAG_DEPTH));
  assign w_empty = (r_count == '0);

  // Loads need a free tag entry; stores never return data so only the
  // LSQ itself can stall them.
  assign w_eligible = r_hold_valid & (r_hold_store | {NUM_SLOTS{~w_full}});

  // Rotating-priority search starting at r_rr_ptr.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (SLOT_W + 1)'(k);
      if (w_cand >= (SLOT_W + 1)'(NUM_SLOTS)) begin
        w_cand = w_cand - (SLOT_W + 1)'(NUM_SLOTS);
      end
      if (!w_found && w_eligible[w_cand[SLOT_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand[SLOT_W-1:0];
      end
    end
  end

  assign w_grant = w_found & ~lsq_full;
  assign w_push  = w_grant & r_hold_load[w_grant_idx];
  // Pop only against tags pushed in earlier cycles: no push-to-pop bypass.
  assign w_pop   = lsq_rd_valid & ~w_empty;

  // Holding registers and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_hold_fn3   <= '0;
      r_hold_load  <= '0;
      r_hold_store <= '0;
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_new_request[i] && !r_hold_valid[i]) begin
          // A request with neither type bit is dropped; both set means load.
          r_hold_valid[i] <= slot_load[i] | slot_store[i];
          r_hold_load[i]  <= slot_load[i];
          r_hold_store[i] <= slot_store[i] & ~slot_load[i];
          r_hold_addr[i]  <= slot_addr[i];
          r_hold_data[i]  <= slot_data[i];
          r_hold_fn3[i]   <= slot_fn3[i];
        end else if (w_grant && (w_grant_idx == SLOT_W'(i))) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
      if (w_grant) begin
        r_rr_ptr <= (w_grant_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  // Tag FIFO and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_mem       <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= w_grant_idx;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (|(slot_new_request & r_hold_valid)) begin
        r_err_overflow <= 1'b1;
      end
      if (lsq_rd_valid && w_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // Output drive
  always_comb begin
    slot_rd_valid = '0;
    if (w_pop) begin
      slot_rd_valid[r_tag_mem[r_rd_ptr]] = 1'b1;
    end
  end

  assign slot_rd_data    = w_pop   ? lsq_rd_data               : '0;
  assign slot_lsq_full   = r_hold_valid;
  assign lsq_new_request = w_grant;
  assign lsq_addr        = w_grant ? r_hold_addr[w_grant_idx]  : '0;
  assign lsq_data        = w_grant ? r_hold_data[w_grant_idx]  : '0;
  assign lsq_fn3         = w_grant ? r_hold_fn3[w_grant_idx]   : 3'b000;
  assign lsq_load        = w_grant & r_hold_load[w_grant_idx];
  assign lsq_store       = w_grant & r_hold_store[w_grant_idx];
  assign err_overflow    = r_err_overflow;
  assign err_underflow   = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rca_lsq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_lsq_arbiter
// Purpose  : Directed self-checking bench for rca_lsq_arbiter (4 slots,
//            4-deep tag FIFO, 32-bit data) with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_lsq_arbiter;

  localparam int NS = 4;
  localparam int XL = 32;

  logic                    clk;
  logic                    rst;
  logic [NS-1:0][XL-1:0]   slot_addr;
  logic [NS-1:0][XL-1:0]   slot_data;
  logic [NS-1:0][2:0]      slot_fn3;
  logic [NS-1:0]           slot_load;
  logic [NS-1:0]           slot_store;
  logic [NS-1:0]           slot_new_request;
  logic [NS-1:0]           slot_lsq_full;
  logic [NS-1:0]           slot_rd_valid;
  logic [XL-1:0]           slot_rd_data;
  logic [XL-1:0]           lsq_addr;
  logic [XL-1:0]           lsq_data;
  logic [2:0]              lsq_fn3;
  logic                    lsq_load;
  logic                    lsq_store;
  logic                    lsq_new_request;
  logic                    lsq_full;
  logic                    lsq_rd_valid;
  logic [XL-1:0]           lsq_rd_data;
  logic                    err_overflow;
  logic                    err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  rca_lsq_arbiter #(.NUM_SLOTS(NS), .TAG_DEPTH(4), .XLEN(XL)) dut (
    .clk              (clk),
    .rst              (rst),
    .slot_addr        (slot_addr),
    .slot_data        (slot_data),
    .slot_fn3         (slot_fn3),
    .slot_load        (slot_load),
    .slot_store       (slot_store),
    .slot_new_request (slot_new_request),
    .slot_lsq_full    (slot_lsq_full),
    .slot_rd_valid    (slot_rd_valid),
    .slot_rd_data     (slot_rd_data),
    .lsq_addr         (lsq_addr),
    .lsq_data         (lsq_data),
    .lsq_fn3          (lsq_fn3),
    .lsq_load         (lsq_load),
    .lsq_store        (lsq_store),
    .lsq_new_request  (lsq_new_request),
    .lsq_full         (lsq_full),
    .lsq_rd_valid     (lsq_rd_valid),
    .lsq_rd_data      (lsq_rd_data),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request on one slot; data and fn3 are derived from the address.
  task automatic req(input int s, input logic ld, input logic st, input logic [31:0] a);
    slot_addr[s]        = a;
    slot_data[s]        = ~a;
    slot_fn3[s]         = a[2:0];
    slot_load[s]        = ld;
    slot_store[s]       = st;
    slot_new_request[s] = 1'b1;
  endtask

  task automatic clr;
    slot_new_request = '0;
  endtask

  initial begin
    logic [3:0] exp_rv [4];
    rst = 1'b0;
    slot_addr = '0; slot_data = '0; slot_fn3 = '0;
    slot_load = '0; slot_store = '0; slot_new_request = '0;
    lsq_full = 1'b0; lsq_rd_valid = 1'b0; lsq_rd_data = '0;

    // Reset state
    #3;
    check("rst_full",   slot_lsq_full,   4'h0);
    check("rst_req",    lsq_new_request, 1'b0);
    check("rst_addr",   lsq_addr,        32'h0);
    check("rst_rv",     slot_rd_valid,   4'h0);
    check("rst_rdata",  slot_rd_data,    32'h0);
    check("rst_ovf",    err_overflow,    1'b0);
    check("rst_unf",    err_underflow,   1'b0);
    tick; tick;
    rst = 1'b1;

    // All four slots store at once: grants 0,1,2,3 back to back
    for (int i = 0; i < 4; i++) req(i, 1'b0, 1'b1, 32'h100 + i);
    tick; clr; #1;
    check("rr_full0",  slot_lsq_full,   4'hF);
    check("rr_req0",   lsq_new_request, 1'b1);
    check("rr_addr0",  lsq_addr,        32'h100);
    check("rr_data0",  lsq_data,        ~32'h100);
    check("rr_fn30",   lsq_fn3,         3'd0);
    check("rr_st0",    lsq_store,       1'b1);
    check("rr_ld0",    lsq_load,        1'b0);
    for (int i = 1; i < 4; i++) begin
      tick;
      check("rr_addr",  lsq_addr,      32'h100 + i);
      check("rr_fullk", slot_lsq_full, (4'hF << i) & 4'hF);
    end
    tick;
    check("rr_idle_req",  lsq_new_request, 1'b0);
    check("rr_idle_full", slot_lsq_full,   4'h0);
    // rr_ptr back at 0: slot 0 wins over slot 1
    req(1, 1'b0, 1'b1, 32'h111);
    req(0, 1'b0, 1'b1, 32'h110);
    tick; clr; #1;
    check("rr_wrap0", lsq_addr, 32'h110);
    tick;
    check("rr_wrap1", lsq_addr, 32'h111);
    tick;

    // Slot 2 load then slot 0 load, data routed back in order
    req(2, 1'b1, 1'b0, 32'h200);
    tick; clr; #1;
    check("ld2_req",  lsq_new_request, 1'b1);
    check("ld2_ld",   lsq_load,        1'b1);
    check("ld2_addr", lsq_addr,        32'h200);
    req(0, 1'b1, 1'b0, 32'h204);
    tick; clr; #1;
    check("ld0_addr", lsq_addr, 32'h204);
    check("ld0_ld",   lsq_load, 1'b1);
    tick;
    lsq_rd_valid = 1'b1; lsq_rd_data = 32'hAAAA; #1;
    check("ret_rv0", slot_rd_valid, 4'b0100);
    check("ret_rd0", slot_rd_data,  32'hAAAA);
    tick;
    lsq_rd_data = 32'hBBBB; #1;
    check("ret_rv1", slot_rd_valid, 4'b0001);
    check("ret_rd1", slot_rd_data,  32'hBBBB);
    tick;
    lsq_rd_valid = 1'b0; #1;
    check("ret_idle_rv", slot_rd_valid, 4'b0000);
    check("ret_idle_rd", slot_rd_data,  32'h0);

    // Fill tag FIFO (rr_ptr=1 -> order 1,2,3,0), then load blocked, store passes
    for (int i = 0; i < 4; i++) req(i, 1'b1, 1'b0, 32'h300 + i);
    tick; clr;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fill_addr", lsq_addr, 32'h300 + ((1 + k) % 4));
      tick;
    end
    req(1, 1'b1, 1'b0, 32'h351);
    req(3, 1'b0, 1'b1, 32'h353);
    tick; clr; #1;
    check("blk_st_req",  lsq_new_request, 1'b1);
    check("blk_st_st",   lsq_store,       1'b1);
    check("blk_st_addr", lsq_addr,        32'h353);
    tick;
    check("blk_ld_req",  lsq_new_request, 1'b0);
    check("blk_ld_full", slot_lsq_full,   4'b0010);
    tick;
    check("blk_ld_req2", lsq_new_request, 1'b0);
    lsq_rd_valid = 1'b1; lsq_rd_data = 32'h11; #1;
    check("blk_pop_rv",  slot_rd_valid,   4'b0010);
    check("blk_pop_req", lsq_new_request, 1'b0);
    tick;
    lsq_rd_valid = 1'b0; #1;
    check("unblk_req",  lsq_new_request, 1'b1);
    check("unblk_ld",   lsq_load,        1'b1);
    check("unblk_addr", lsq_addr,        32'h351);
    tick;
    exp_rv[0] = 4'b0100; exp_rv[1] = 4'b1000; exp_rv[2] = 4'b0001; exp_rv[3] = 4'b0010;
    lsq_rd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lsq_rd_data = 32'h20 + k; #1;
      check("drain_rv", slot_rd_valid, exp_rv[k]);
      check("drain_rd", slot_rd_data,  32'h20 + k);
      tick;
    end
    lsq_rd_valid = 1'b0; #1;
    check("drain_unf", err_underflow, 1'b0);

    // lsq_full for 5 cycles, second strobe on busy slot 0
    lsq_full = 1'b1;
    req(0, 1'b0, 1'b1, 32'h400);
    tick; clr; #1;
    check("ovf_pre", err_overflow, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req(0, 1'b0, 1'b1, 32'h4FF);
      #1;
      check("ovf_stall", lsq_new_request, 1'b0);
      tick; clr;
    end
    check("ovf_flag", err_overflow, 1'b1);
    lsq_full = 1'b0; #1;
    check("ovf_issue",      lsq_new_request, 1'b1);
    check("ovf_issue_addr", lsq_addr,        32'h400);
    tick;
    check("ovf_once",   lsq_new_request, 1'b0);
    check("ovf_sticky", err_overflow,    1'b1);

    // Neither type bit: dropped; both bits: treated as load
    req(1, 1'b0, 1'b0, 32'h500);
    tick; clr; #1;
    check("none_full", slot_lsq_full, 4'h0);
    req(1, 1'b1, 1'b1, 32'h501);
    tick; clr; #1;
    check("both_ld", lsq_load,  1'b1);
    check("both_st", lsq_store, 1'b0);
    tick;
    lsq_rd_valid = 1'b1; lsq_rd_data = 32'h55; #1;
    check("both_rv", slot_rd_valid, 4'b0010);
    tick;
    lsq_rd_valid = 1'b0;

    // Return with empty tag FIFO
    #1;
    check("unf_pre", err_underflow, 1'b0);
    lsq_rd_valid = 1'b1; lsq_rd_data = 32'hDEAD; #1;
    check("unf_rv", slot_rd_valid, 4'h0);
    check("unf_rd", slot_rd_data,  32'h0);
    tick;
    lsq_rd_valid = 1'b0; #1;
    check("unf_flag", err_underflow, 1'b1);
    tick;
    check("unf_sticky", err_underflow, 1'b1);

    // Reset with 2 loads outstanding and 3 held requests
    req(0, 1'b1, 1'b0, 32'h600);
    req(1, 1'b1, 1'b0, 32'h601);
    tick; clr; tick; tick;
    lsq_full = 1'b1;
    req(1, 1'b0, 1'b1, 32'h611);
    req(2, 1'b0, 1'b1, 32'h612);
    req(3, 1'b0, 1'b1, 32'h613);
    tick; clr; #1;
    check("mid_full", slot_lsq_full, 4'b1110);
    #1;
    rst = 1'b0; lsq_full = 1'b0; #1;
    check("mid_rst_full", slot_lsq_full,   4'h0);
    check("mid_rst_req",  lsq_new_request, 1'b0);
    check("mid_rst_addr", lsq_addr,        32'h0);
    check("mid_rst_ovf",  err_overflow,    1'b0);
    check("mid_rst_unf",  err_underflow,   1'b0);
    tick;
    rst = 1'b1;
    req(2, 1'b0, 1'b1, 32'h700);
    lsq_rd_valid = 1'b1; lsq_rd_data = 32'h77; #1;
    check("post_rst_rv", slot_rd_valid, 4'h0);
    tick; clr;
    lsq_rd_valid = 1'b0; #1;
    check("post_rst_unf",  err_underflow,   1'b1);
    check("post_rst_req",  lsq_new_request, 1'b1);
    check("post_rst_addr", lsq_addr,        32'h700);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
